// File: rtl/capture_pkg.sv
// Shared types and helpers for the logic-analyzer capture controller.
package capture_pkg;

  typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} capt_state_t;

  // Post-trigger count is kept in [1, entries-1] so at least one pre sample exists.
  function automatic int clamp_post(input int trig_pos, input int entries);
    if (trig_pos < 1) return 1;
    if (trig_pos > entries - 1) return entries - 1;
    return trig_pos;
  endfunction

endpackage

// File: rtl/capture_engine_if.sv
// Control/status bundle between the command block and the capture engine.
interface capture_engine_if #(parameter int LOG2 = 9);

  logic            wrt_smpl;
  logic            run;
  logic [LOG2-1:0] trig_pos;
  logic            trig_in;
  logic            clr_done;
  logic            rd_next;
  logic            we;
  logic [LOG2-1:0] waddr;
  logic [LOG2-1:0] raddr;
  logic            armed;
  logic            triggered;
  logic            capture_done;
  logic            rd_last;

  modport master (
    output wrt_smpl, run, trig_pos, trig_in, clr_done, rd_next,
    input  we, waddr, raddr, armed, triggered, capture_done, rd_last
  );

  modport slave (
    input  wrt_smpl, run, trig_pos, trig_in, clr_done, rd_next,
    output we, waddr, raddr, armed, triggered, capture_done, rd_last
  );

endinterface

// File: rtl/capture_engine_ring_addr_ctr.sv
// Modulo-ENTRIES address counter with synchronous load; load has priority over inc.
module ring_addr_ctr #(
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inc,
  input  logic            load,
  input  logic [LOG2-1:0] load_val,
  output logic [LOG2-1:0] addr,
  output logic [LOG2-1:0] nxt
);

  localparam logic [LOG2-1:0] LAST = LOG2'(ENTRIES - 1);

  assign nxt = (addr == LAST) ? '0 : addr + LOG2'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    addr <= '0;
    else if (load) addr <= load_val;
    else if (inc)  addr <= nxt;
  end

endmodule

// File: rtl/capture_engine.sv
// Circular-buffer capture sequencer with wrap-aware readout.
// Optional CAPTURE_SW_TRIG_EN adds a force_trig input that triggers from PRE or ARMED.
module capture_engine
  import capture_pkg::*;
#(
  parameter int NUM_CH  = 5,
  parameter int ENTRIES = 384,
  parameter int LOG2    = 9
) (
  input  logic clk,
  input  logic rst_n,
`ifdef CAPTURE_SW_TRIG_EN
  input  logic force_trig,
`endif
  capture_engine_if.slave bus
);

  localparam logic [LOG2-1:0] LAST_ADDR = LOG2'(ENTRIES - 1);

  if (ENTRIES > (1 << LOG2) || ENTRIES < 2 || NUM_CH < 1) begin : g_cfg_check
    $error("capture_engine: invalid NUM_CH/ENTRIES/LOG2 combination");
  end

  capt_state_t     state, state_nxt;
  logic            armed_q, armed_nxt, trig_q, trig_nxt, done_q, done_nxt;
  logic            rd_last_q, rd_last_nxt;
  logic [LOG2-1:0] smpl_cnt, smpl_cnt_nxt, post_cnt, post_cnt_nxt, post_p, post_p_nxt;
  logic [LOG2-1:0] pre_target, waddr, waddr_nxt, raddr, raddr_nxt, newest, r_load_val;
  logic            w_inc, w_load, r_inc, r_load, capturing, wr, trig_force;

`ifdef CAPTURE_SW_TRIG_EN
  assign trig_force = force_trig;
`else
  assign trig_force = 1'b0;
`endif

  assign capturing  = (state == PRE) || (state == ARMED) || (state == POST);
  assign wr         = bus.wrt_smpl & capturing;
  assign pre_target = LOG2'(ENTRIES - int'(post_p));
  assign newest     = (waddr == '0) ? LAST_ADDR : waddr - LOG2'(1);

  ring_addr_ctr #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_waddr (
    .clk(clk), .rst_n(rst_n), .inc(w_inc), .load(w_load),
    .load_val({LOG2{1'b0}}), .addr(waddr), .nxt(waddr_nxt)
  );

  ring_addr_ctr #(.ENTRIES(ENTRIES), .LOG2(LOG2)) u_raddr (
    .clk(clk), .rst_n(rst_n), .inc(r_inc), .load(r_load),
    .load_val(r_load_val), .addr(raddr), .nxt(raddr_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      armed_q   <= 1'b0;
      trig_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_last_q <= 1'b0;
      smpl_cnt  <= '0;
      post_cnt  <= '0;
      post_p    <= LOG2'(1);
    end else begin
      state     <= state_nxt;
      armed_q   <= armed_nxt;
      trig_q    <= trig_nxt;
      done_q    <= done_nxt;
      rd_last_q <= rd_last_nxt;
      smpl_cnt  <= smpl_cnt_nxt;
      post_cnt  <= post_cnt_nxt;
      post_p    <= post_p_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    armed_nxt    = armed_q;
    trig_nxt     = trig_q;
    done_nxt     = done_q;
    rd_last_nxt  = rd_last_q;
    smpl_cnt_nxt = smpl_cnt;
    post_cnt_nxt = post_cnt;
    post_p_nxt   = post_p;
    w_inc        = wr;
    w_load       = 1'b0;
    r_inc        = 1'b0;
    r_load       = 1'b0;
    r_load_val   = '0;
    unique case (state)
      IDLE: begin
        smpl_cnt_nxt = '0;
        post_cnt_nxt = '0;
        armed_nxt    = 1'b0;
        trig_nxt     = 1'b0;
        done_nxt     = 1'b0;
        rd_last_nxt  = 1'b0;
        w_load       = 1'b1;
        r_load       = 1'b1;
        if (bus.run) begin
          state_nxt  = PRE;
          post_p_nxt = LOG2'(clamp_post(int'(bus.trig_pos), ENTRIES));
        end
      end
      PRE: begin
        if (wr) smpl_cnt_nxt = smpl_cnt + LOG2'(1);
        if (trig_force) begin
          state_nxt    = POST;
          trig_nxt     = 1'b1;
          post_cnt_nxt = '0;
        end else if (wr && (smpl_cnt + LOG2'(1) == pre_target)) begin
          state_nxt = ARMED;
          armed_nxt = 1'b1;
        end
      end
      // A write coinciding with the trigger belongs to the pre-trigger region.
      ARMED: begin
        if (bus.trig_in || trig_force) begin
          state_nxt    = POST;
          trig_nxt     = 1'b1;
          post_cnt_nxt = '0;
        end
      end
      POST: begin
        if (wr) begin
          post_cnt_nxt = post_cnt + LOG2'(1);
          if (post_cnt + LOG2'(1) == post_p) begin
            state_nxt   = DONE;
            done_nxt    = 1'b1;
            armed_nxt   = 1'b0;
            r_load      = 1'b1;
            r_load_val  = waddr_nxt;
            rd_last_nxt = 1'b0;
          end
        end
      end
      DONE: begin
        if (bus.clr_done) begin
          state_nxt   = IDLE;
          armed_nxt   = 1'b0;
          trig_nxt    = 1'b0;
          done_nxt    = 1'b0;
          rd_last_nxt = 1'b0;
          w_load      = 1'b1;
          r_load      = 1'b1;
        end else if (bus.rd_next) begin
          r_inc       = 1'b1;
          rd_last_nxt = (raddr_nxt == newest);
        end
      end
      default: state_nxt = IDLE;
    endcase
    if (capturing && !bus.run) begin
      state_nxt    = IDLE;
      armed_nxt    = 1'b0;
      trig_nxt     = 1'b0;
      done_nxt     = 1'b0;
      rd_last_nxt  = 1'b0;
      smpl_cnt_nxt = '0;
      post_cnt_nxt = '0;
      w_load       = 1'b1;
      r_load       = 1'b1;
      r_load_val   = '0;
    end
  end

  assign bus.we           = wr;
  assign bus.waddr        = waddr;
  assign bus.raddr        = raddr;
  assign bus.armed        = armed_q;
  assign bus.triggered    = trig_q;
  assign bus.capture_done = done_q;
  assign bus.rd_last      = rd_last_q;

endmodule

// File: tb/tb_capture_engine.sv
// Self-checking bench for capture_engine: clamp vectors, hand sequences, random run vs a write-count model.
module tb_capture_engine;

  localparam int E    = 384;
  localparam int LOG2 = 9;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic force_trig = 1'b0;

  always #5 clk = ~clk;

  capture_engine_if #(.LOG2(LOG2)) bus();

  capture_engine #(.NUM_CH(5), .ENTRIES(E), .LOG2(LOG2)) dut (
    .clk(clk),
    .rst_n(rst_n),
`ifdef CAPTURE_SW_TRIG_EN
    .force_trig(force_trig),
`endif
    .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  // Model state: capture described by write counts, not by controller phases.
  bit m_cap, m_done, m_trig_armed;
  int m_n, m_trig_at, m_p, m_k;

  function automatic int clamp_tp(input int tp);
    if (tp < 1) return 1;
    if (tp > E - 1) return E - 1;
    return tp;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    int n_new;
    int ta_new;
    bit arm_new;
    if (!rst_n) begin
      m_cap <= 1'b0; m_done <= 1'b0; m_n <= 0; m_trig_at <= -1;
      m_trig_armed <= 1'b0; m_p <= 1; m_k <= 0;
    end else if (m_done) begin
      if (bus.clr_done) begin
        m_done <= 1'b0; m_n <= 0; m_trig_at <= -1; m_k <= 0;
      end else if (bus.rd_next) begin
        m_k <= m_k + 1;
      end
    end else if (!m_cap) begin
      if (bus.run) begin
        m_cap <= 1'b1; m_p <= clamp_tp(int'(bus.trig_pos));
        m_n <= 0; m_trig_at <= -1; m_k <= 0;
      end
    end else if (!bus.run) begin
      m_cap <= 1'b0; m_n <= 0; m_trig_at <= -1;
    end else begin
      n_new   = m_n + (bus.wrt_smpl ? 1 : 0);
      ta_new  = m_trig_at;
      arm_new = m_trig_armed;
      if (m_trig_at < 0 && (force_trig || (bus.trig_in && m_n >= E - m_p))) begin
        ta_new  = n_new;
        arm_new = (m_n >= E - m_p);
      end
      m_n <= n_new; m_trig_at <= ta_new; m_trig_armed <= arm_new;
      if (ta_new >= 0 && n_new - ta_new >= m_p) begin
        m_cap <= 1'b0; m_done <= 1'b1;
      end
    end
  end

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkOutput();
    int e_raddr;
    e_raddr = m_done ? (m_n + m_k) % E : 0;
    check_val("we", int'(bus.we), int'(m_cap && bus.wrt_smpl));
    check_val("waddr", int'(bus.waddr), m_n % E);
    check_val("raddr", int'(bus.raddr), e_raddr);
    check_val("armed", int'(bus.armed),
              int'(m_cap && ((m_trig_at >= 0) ? m_trig_armed : (m_n >= E - m_p))));
    check_val("triggered", int'(bus.triggered), int'(m_trig_at >= 0));
    check_val("capture_done", int'(bus.capture_done), int'(m_done));
    check_val("rd_last", int'(bus.rd_last), int'(m_done && e_raddr == (m_n + E - 1) % E));
  endtask

  task automatic applyStimulus(input bit wr, input bit trig, input bit clr, input bit rdn);
    bus.wrt_smpl = wr;
    bus.trig_in  = trig;
    bus.clr_done = clr;
    bus.rd_next  = rdn;
    #3;
    checkOutput();
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    bus.run = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  typedef struct {
    int trig_pos;
    int arm_writes;
    int post_writes;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #5_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin : main
    int cnt;
    int last_hits;
    vecs[0] = '{128, 256, 128};
    vecs[1] = '{0,   383, 1};
    vecs[2] = '{500, 1,   383};
    vecs[3] = '{383, 1,   383};
    vecs[4] = '{1,   383, 1};
    vecs[5] = '{200, 184, 200};

    bus.wrt_smpl = 1'b1; bus.trig_in = 1'b0; bus.clr_done = 1'b0;
    bus.rd_next = 1'b0; bus.run = 1'b0; bus.trig_pos = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_we", int'(bus.we), 0);
    check_val("rst_waddr", int'(bus.waddr), 0);
    check_val("rst_raddr", int'(bus.raddr), 0);
    check_val("rst_flags", int'({bus.armed, bus.triggered, bus.capture_done, bus.rd_last}), 0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

    // Nominal capture: 256 pre writes, 100 extra, trigger, 128 post writes with wrap.
    bus.trig_pos = 9'd128; bus.run = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 356; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 255) check_val("armed_before_256", int'(bus.armed), 0);
      if (i == 256) check_val("armed_at_256", int'(bus.armed), 1);
    end
    check_val("waddr_356", int'(bus.waddr), 356);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("trig_accept", int'(bus.triggered), 1);
    for (int i = 1; i <= 128; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      if (i == 28)  check_val("waddr_wrap", int'(bus.waddr), 0);
      if (i == 127) check_val("done_early", int'(bus.capture_done), 0);
    end
    check_val("done_at_128", int'(bus.capture_done), 1);
    check_val("final_waddr", int'(bus.waddr), 100);
    check_val("raddr_oldest", int'(bus.raddr), 100);
    bus.wrt_smpl = 1'b1;
    #1;
    check_val("we_in_done", int'(bus.we), 0);

    last_hits = 0;
    for (int k = 0; k < E; k++) begin
      check_val("readout_addr", int'(bus.raddr), (100 + k) % E);
      if (bus.rd_last) begin
        last_hits++;
        check_val("rd_last_addr", int'(bus.raddr), 99);
      end
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    end
    check_val("readout_wrap", int'(bus.raddr), 100);
    check_val("rd_last_hits", last_hits, 1);

    // clr_done with run held high: one IDLE cycle, then a fresh PRE.
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
    check_val("clr_done", int'(bus.capture_done), 0);
    check_val("clr_trig", int'(bus.triggered), 0);
    check_val("clr_waddr", int'(bus.waddr), 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("restart_waddr", int'(bus.waddr), 1);

    // Trigger during PRE is ignored; later trigger accepted; then abort in POST.
    bus.trig_pos = 9'd5;
    for (int i = 2; i <= 256; i++) begin
      applyStimulus(1'b1, (i == 100), 1'b0, 1'b0);
      if (i == 100) check_val("pre_trig_ignored", int'(bus.triggered), 0);
    end
    check_val("armed_after_prefill", int'(bus.armed), 1);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
    check_val("late_trig", int'(bus.triggered), 1);
    repeat (5) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    bus.run = 1'b0;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    check_val("abort_done", int'(bus.capture_done), 0);
    check_val("abort_waddr", int'(bus.waddr), 0);
    check_val("abort_flags", int'({bus.armed, bus.triggered}), 0);

    // Clamp table: writes needed to arm and post writes needed to finish.
    foreach (vecs[v]) begin
      go_idle();
      bus.trig_pos = 9'(vecs[v].trig_pos);
      bus.run = 1'b1;
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
      cnt = 0;
      while (!bus.armed && cnt < 400) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cnt++;
      end
      check_val($sformatf("arm_writes_tp%0d", vecs[v].trig_pos), cnt, vecs[v].arm_writes);
      applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
      check_val("vec_trig", int'(bus.triggered), 1);
      cnt = 0;
      while (!bus.capture_done && cnt < 400) begin
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        cnt++;
      end
      check_val($sformatf("post_writes_tp%0d", vecs[v].trig_pos), cnt, vecs[v].post_writes);
    end

`ifdef CAPTURE_SW_TRIG_EN
    go_idle();
    bus.trig_pos = 9'd50;
    bus.run = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
    repeat (9) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    force_trig = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
    force_trig = 1'b0;
    check_val("force_trig", int'(bus.triggered), 1);
    check_val("force_armed", int'(bus.armed), 0);
    cnt = 0;
    while (!bus.capture_done && cnt < 400) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
      cnt++;
    end
    check_val("force_post_writes", cnt, 50);
`endif

    // Randomized traffic; trig_pos changes every cycle to exercise sampling at start.
    go_idle();
    for (int c = 0; c < 8000; c++) begin
      case ($urandom_range(0, 3))
        0:       bus.trig_pos = 9'($urandom_range(0, 8));
        1:       bus.trig_pos = 9'($urandom_range(375, 511));
        2:       bus.trig_pos = 9'($urandom_range(0, 511));
        default: bus.trig_pos = 9'd200;
      endcase
      bus.run = ($urandom_range(0, 1999) != 0);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 99) < 3,
                    $urandom_range(0, 99) < 2, $urandom_range(0, 1) == 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
